// File: rtl/temp_converter.sv
// Temperature conditioning: moving average of ADT7420 readings, then rounded and
// clamped Celsius/Fahrenheit bytes for the two-digit display.
module temp_converter #(
  parameter int AVG_LOG2  = 3,
  parameter int CLAMP_MAX = 99
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [15:0] temp_raw,
  input  logic        temp_valid,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  c_data,
  output logic [7:0]  f_data,
  output logic        data_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = AVG_LOG2 + 13;
  localparam logic [9:0]  CLAMP10 = 10'(CLAMP_MAX);
  localparam logic [12:0] CLAMP13 = 13'(CLAMP_MAX);
  localparam logic [7:0]  CLAMP8  = 8'(CLAMP_MAX);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SCALE, S_DIV, S_OUT} state_e;

  state_e                state_q, state_d;
  logic signed [12:0]    sample_q, sample_d;
  logic signed [12:0]    buf_q [DEPTH];
  logic [AVG_LOG2-1:0]   wptr_q, wptr_d;
  logic                  primed_q, primed_d;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic signed [12:0]    avg_q, avg_d;
  logic                  fzero_q, fzero_d;
  logic [2:0]            rem_q, rem_d;
  logic [15:0]           quo_q, quo_d;
  logic [3:0]            iter_q, iter_d;
  logic [7:0]            c_q, c_d, f_q, f_d;
  logic                  dv_q, dv_d;

  logic signed [12:0] avg_w;
  logic signed [16:0] x_w;
  logic [3:0]         trial_w;
  logic               ge_w;
  logic [13:0]        c_sum_w;
  logic [9:0]         c_round_w;
  logic [16:0]        f_sum_w;
  logic [12:0]        f_round_w;
  logic               unused_raw_bits;

  assign unused_raw_bits = ^temp_raw[2:0];

  assign avg_w     = 13'(sum_q >>> AVG_LOG2);
  assign x_w       = 17'(avg_w) * 17'sd9 + 17'sd2560;
  assign trial_w   = {rem_q, quo_q[15]};
  assign ge_w      = (trial_w >= 4'd5);
  assign c_sum_w   = {2'b00, avg_q[11:0]} + 14'd8;
  assign c_round_w = 10'(c_sum_w >> 4);
  assign f_sum_w   = {1'b0, quo_q} + 17'd8;
  assign f_round_w = 13'(f_sum_w >> 4);

  assign busy       = (state_q != S_IDLE);
  assign overrun    = temp_valid && busy && !reset;
  assign c_data     = c_q;
  assign f_data     = f_q;
  assign data_valid = dv_q;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    wptr_d   = wptr_q;
    primed_d = primed_q;
    sum_d    = sum_q;
    avg_d    = avg_q;
    fzero_d  = fzero_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    iter_d   = iter_q;
    c_d      = c_q;
    f_d      = f_q;
    dv_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (temp_valid) begin
          sample_d = temp_raw[15:3];
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // First sample after reset fills the whole window so the average starts settled.
        if (!primed_q) begin
          sum_d    = SW'(sample_q) <<< AVG_LOG2;
          primed_d = 1'b1;
        end else begin
          sum_d = sum_q - SW'(buf_q[wptr_q]) + SW'(sample_q);
        end
        wptr_d  = wptr_q + AVG_LOG2'(1);
        state_d = S_SCALE;
      end
      S_SCALE: begin
        avg_d   = avg_w;
        fzero_d = (x_w <= 17'sd0);
        quo_d   = (x_w <= 17'sd0) ? 16'd0 : x_w[15:0];
        rem_d   = 3'd0;
        iter_d  = 4'd0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d  = ge_w ? 3'(trial_w - 4'd5) : trial_w[2:0];
        quo_d  = {quo_q[14:0], ge_w};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = S_OUT;
      end
      S_OUT: begin
        if (avg_q[12])                c_d = 8'd0;
        else if (c_round_w > CLAMP10) c_d = CLAMP8;
        else                          c_d = c_round_w[7:0];
        if (fzero_q)                  f_d = 8'd0;
        else if (f_round_w > CLAMP13) f_d = CLAMP8;
        else                          f_d = f_round_w[7:0];
        dv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives in always_comb.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sample_q <= '0;
      wptr_q   <= '0;
      primed_q <= 1'b0;
      sum_q    <= '0;
      avg_q    <= '0;
      fzero_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      iter_q   <= '0;
      c_q      <= '0;
      f_q      <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      wptr_q   <= wptr_d;
      primed_q <= primed_d;
      sum_q    <= sum_d;
      avg_q    <= avg_d;
      fzero_q  <= fzero_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      iter_q   <= iter_d;
      c_q      <= c_d;
      f_q      <= f_d;
      dv_q     <= dv_d;
    end
  end

  // NOTE: the history buffer has no reset; clearing primed makes the next sample overwrite every entry.
  always_ff @(posedge clk_100MHz) begin
    if (state_q == S_ACCUM) begin
      if (!primed_q) begin
        for (int i = 0; i < DEPTH; i++) buf_q[i] <= sample_q;
      end else begin
        buf_q[wptr_q] <= sample_q;
      end
    end
  end

endmodule

// File: tb/tb_temp_converter.sv
// Randomized self-checking bench for temp_converter against a window-average model.
module tb_temp_converter;

  localparam int DEPTH     = 8;
  localparam int CLAMP_MAX = 99;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] temp_raw = '0;
  logic        temp_valid = 1'b0;
  logic        busy, overrun, data_valid;
  logic [7:0]  c_data, f_data;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt   = 0;
  int ovr_cnt  = 0;
  int hist[$];
  int exp_c = 0;
  int exp_f = 0;

  temp_converter #(.AVG_LOG2(3), .CLAMP_MAX(CLAMP_MAX)) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .temp_raw(temp_raw),
    .temp_valid(temp_valid),
    .busy(busy),
    .overrun(overrun),
    .c_data(c_data),
    .f_data(f_data),
    .data_valid(data_valid)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) begin
    dv_cnt  <= dv_cnt + (data_valid ? 1 : 0);
    ovr_cnt <= ovr_cnt + (overrun ? 1 : 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int min_clamp(input int v);
    return (v > CLAMP_MAX) ? CLAMP_MAX : v;
  endfunction

  // Reference: keep the last DEPTH accepted temperatures, average, convert.
  function automatic void model_push(input logic [15:0] raw);
    int t, sum, avg, x;
    t = int'($signed(raw[15:3]));
    if (hist.size() == 0) begin
      for (int i = 0; i < DEPTH; i++) hist.push_back(t);
    end else begin
      hist.push_back(t);
      void'(hist.pop_front());
    end
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    avg = (sum >= 0) ? sum / DEPTH : -((-sum + DEPTH - 1) / DEPTH);
    x = 9 * avg + 2560;
    exp_c = (avg < 0) ? 0 : min_clamp((avg + 8) / 16);
    exp_f = (x <= 0) ? 0 : min_clamp((x / 5 + 8) / 16);
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk_100MHz);
    reset = 1'b1;
    repeat (cycles) @(negedge clk_100MHz);
    reset = 1'b0;
    hist.delete();
  endtask

  task automatic strobe(input logic [15:0] raw);
    @(negedge clk_100MHz);
    temp_raw   = raw;
    temp_valid = 1'b1;
    @(posedge clk_100MHz);
    #1;
    temp_valid = 1'b0;
  endtask

  // Wait (bounded) for data_valid; returns cycles since strobe edge and busy count.
  task automatic wait_dv(input string tag, output int lat, output int nbusy);
    lat   = 0;
    nbusy = busy ? 1 : 0;
    while (!data_valid && lat < 40) begin
      @(posedge clk_100MHz);
      #1;
      lat++;
      nbusy += busy ? 1 : 0;
    end
    if (!data_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic convert(input string tag, input logic [15:0] raw);
    int lat, nbusy, c_hold;
    strobe(raw);
    model_push(raw);
    wait_dv(tag, lat, nbusy);
    check({tag, "_latency"}, lat, 19);
    check({tag, "_busy_cycles"}, nbusy, 19);
    check({tag, "_c"}, int'(c_data), exp_c);
    check({tag, "_f"}, int'(f_data), exp_f);
    c_hold = int'(c_data);
    @(posedge clk_100MHz);
    #1;
    check({tag, "_dv_pulse"}, int'(data_valid), 0);
    check({tag, "_c_hold"}, int'(c_data), c_hold);
  endtask

  initial begin
    int lat, nbusy, dv0, ov0;

    repeat (3) @(posedge clk_100MHz);
    #1;
    check("rst_c", int'(c_data), 0);
    check("rst_f", int'(f_data), 0);
    check("rst_dv", int'(data_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(overrun), 0);
    do_reset(1);

    convert("c25", 16'h0C80);
    check("c25_abs_c", int'(c_data), 25);
    check("c25_abs_f", int'(f_data), 77);
    convert("c33", 16'h1080);
    check("c33_abs_c", int'(c_data), 26);
    check("c33_abs_f", int'(f_data), 79);

    do_reset(2);
    convert("m20", 16'hF600);
    check("m20_abs_f", int'(f_data), 0);
    do_reset(2);
    convert("m10", 16'hFB00);
    check("m10_abs_f", int'(f_data), 14);
    do_reset(2);
    convert("c50", 16'h1900);
    check("c50_abs_c", int'(c_data), 50);
    check("c50_abs_f", int'(f_data), 99);

    // Strobe while busy is dropped and flagged.
    do_reset(2);
    ov0 = ovr_cnt;
    strobe(16'h0C80);
    model_push(16'h0C80);
    repeat (4) @(posedge clk_100MHz);
    strobe(16'h1900);
    wait_dv("ovr", lat, nbusy);
    check("ovr_latency", lat, 14);
    check("ovr_c", int'(c_data), 25);
    check("ovr_pulses", ovr_cnt - ov0, 1);
    convert("ovr_next", 16'h0C80);
    check("ovr_next_abs_c", int'(c_data), 25);

    // Reset mid-conversion aborts and clears the window.
    strobe(16'h0C80);
    dv0 = dv_cnt;
    repeat (9) @(posedge clk_100MHz);
    do_reset(1);
    repeat (30) @(posedge clk_100MHz);
    #1;
    check("abort_no_dv", dv_cnt - dv0, 0);
    check("abort_c", int'(c_data), 0);
    check("abort_f", int'(f_data), 0);
    check("abort_busy", int'(busy), 0);
    convert("repre", 16'h1080);
    check("repre_abs_c", int'(c_data), 33);
    check("repre_abs_f", int'(f_data), 91);

    // Reset and strobe together: sample discarded.
    @(negedge clk_100MHz);
    reset = 1'b1;
    temp_raw = 16'h1900;
    temp_valid = 1'b1;
    @(negedge clk_100MHz);
    temp_valid = 1'b0;
    reset = 1'b0;
    hist.delete();
    check("rstv_busy", int'(busy), 0);
    check("rstv_c", int'(c_data), 0);

    // Randomized window traffic with occasional resets.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] raw;
      logic [12:0] t13;
      if (i % 2 == 0) begin
        raw = 16'($urandom);
      end else begin
        t13 = 13'($urandom_range(0, 2400)) - 13'd800;
        raw = {t13, 3'($urandom)};
      end
      if ($urandom_range(0, 9) == 0) do_reset(1);
      convert("rnd", raw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_converter.md
# temp_converter

Upstream conditioning stage between the I2C temperature master and the 7-segment driver. Accepts raw ADT7420-format readings, keeps a moving average over the last 2^AVG_LOG2 samples, and converts the average to rounded, clamped, unsigned integer Celsius and Fahrenheit bytes. Those bytes drive the display's `c_data` and `f_data` inputs directly. Fahrenheit scaling uses a sequential restoring divider, so each conversion takes a fixed number of cycles.

## Interface
- `AVG_LOG2`, default 3: log2 of averaging depth (window = 8 samples).
- `CLAMP_MAX`, default 99: upper clamp for both outputs (two-digit display).
- `clk_100MHz`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `temp_raw`  in  16  ADT7420 word: [15:3] two's-complement temperature, 1/16 °C per LSB; [2:0] ignored.
- `temp_valid`  in  1  single-cycle strobe; `temp_raw` is valid while this is high.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  one-cycle pulse when `temp_valid` arrives while `busy`.
- `c_data`  out  8  Celsius, 0..CLAMP_MAX.
- `f_data`  out  8  Fahrenheit, 0..CLAMP_MAX.
- `data_valid`  out  1  one-cycle pulse when `c_data`/`f_data` update.

## Operation
- Sample `s` = sign-extended `temp_raw[15:3]`, 13-bit signed.
- History buffer: 2^AVG_LOG2 signed 13-bit entries, write pointer `wptr`, signed accumulator `sum` of AVG_LOG2+13 bits, and a `primed` flag.
- FSM states:
  - **IDLE**: on `temp_valid`, latch `s` and go to ACCUM.
  - **ACCUM**:
    - If `primed`=0: every buffer entry = `s`, `sum` = `s` << AVG_LOG2, set `primed`.
    - Otherwise: `sum` = `sum` − buf[wptr] + `s`, buf[wptr] = `s`.
    - In both cases `wptr` increments, wrapping modulo depth. Go to SCALE.
  - **SCALE**: compute `avg` = `sum` >>> AVG_LOG2 (arithmetic) and `x` = 9·`avg` + 2560, as 17-bit signed.
    - If `x` ≤ 0, set `fzero`.
    - Otherwise load the divider with dividend `x[15:0]` and divisor 5.
    - Go to DIV with iteration count 0.
  - **DIV**: one restoring-division quotient bit per cycle, MSB first, 16 cycles, giving `q` = floor(`x`/5) in 1/16 °F units. After iteration 15, go to OUT. When `fzero` is set the divider still runs its 16 cycles, so latency stays fixed.
  - **OUT**:
    - `c_data` = 0 if `avg` < 0, else min((`avg`+8) >> 4, CLAMP_MAX).
    - `f_data` = 0 if `fzero`, else min((`q`+8) >> 4, CLAMP_MAX).
    - Pulse `data_valid`; go to IDLE.
- Width rule: maximum `x` is 9·4095 + 2560 = 39415, so it fits 16 unsigned bits. Clamp comparisons use the full-width value before truncating to 8 bits.
- `temp_valid` outside IDLE: the sample is dropped (it does not enter the buffer) and `overrun` pulses in the same cycle the strobe is sampled.

## Timing
- Reset values: `c_data`=0, `f_data`=0, `data_valid`=0, `busy`=0, `overrun`=0. State is IDLE, `wptr`=0, `primed`=0, `sum`=0.
- Call the edge that samples `temp_valid` in IDLE edge 0. Then:
  - ACCUM occupies edge 1.
  - SCALE occupies edge 2.
  - DIV occupies edges 3–18.
  - OUT registers the outputs at edge 19.
  - `data_valid` is high for the single cycle after edge 19.
- `busy` rises after edge 0 and falls after edge 19.
- Back-to-back: a new `temp_valid` is accepted on the cycle `data_valid` is high, because the FSM is already in IDLE. Minimum accepted strobe period is 20 cycles.
- `c_data` and `f_data` hold their values between updates.
- Reset mid-operation, in any state: abort the conversion, apply the reset values, emit no `data_valid`, and clear `primed`. The next sample preloads the buffer.
- `reset` and `temp_valid` high together: reset wins and the sample is discarded.

## Test plan
- Reset, then `temp_raw`=16'h0C80 (25.0 °C) strobed once -> `data_valid` 19 cycles later, `c_data`=25, `f_data`=77; `busy` high for exactly 19 cycles.
- Continuing, `temp_raw`=16'h1080 (33.0 °C) -> `avg`=416 (26.0 °C), `c_data`=26, `f_data`=79.
- Reset, then 16'hF600 (−20 °C) -> `c_data`=0, `f_data`=0 (`x`=−320). Reset, then 16'hFB00 (−10 °C) -> `c_data`=0, `f_data`=14.
- Reset, then 16'h1900 (50 °C) -> `c_data`=50, `f_data` clamped to 99 (unclamped value 122).
- Reset, strobe 16'h0C80, then strobe 16'h1900 five cycles later -> `overrun` pulses once. The output is from 25 °C only (`c_data`=25). The next accepted 25 °C sample still averages to 25, confirming the dropped sample never entered the buffer.
- Strobe 16'h0C80, assert `reset` for 1 cycle 10 cycles later -> no `data_valid`, outputs 0. Then strobe 16'h1080 -> `c_data`=33, `f_data`=91, confirming the buffer was re-preloaded.
